// File: rtl/rsa_pkg.sv
// Shared constants and loader state encoding for the RSA datapath.
package rsa_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH  = 5;
  localparam int unsigned TOTAL_ADDR  = 2 ** ADDR_WIDTH;
  localparam int unsigned DATA_LENGTH = DATA_WIDTH * TOTAL_ADDR;
  localparam int unsigned CNT_WIDTH   = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } ld_state_e;

endpackage

// File: rtl/rsa_operand_loader_if.sv
// Serial operand lanes in, assembled operands and status out.
interface rsa_operand_loader_if;
  import rsa_pkg::*;

  logic                   startInput;
  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  m_input;
  logic [DATA_WIDTH-1:0]  e_input;
  logic [DATA_WIDTH-1:0]  n_input;
  logic                   consume;
  logic [DATA_LENGTH-1:0] m_reg;
  logic [DATA_LENGTH-1:0] e_reg;
  logic [DATA_LENGTH-1:0] n_reg;
  logic [CNT_WIDTH-1:0]   word_cnt;
  logic                   busy;
  logic                   operands_ready;
  logic                   overrun;
  logic                   n_even;

  // Producer side: drives words and handshakes, observes operands.
  modport master (
    output startInput, in_valid, m_input, e_input, n_input, consume,
    input  m_reg, e_reg, n_reg, word_cnt, busy, operands_ready, overrun, n_even
  );

  // Loader side.
  modport slave (
    input  startInput, in_valid, m_input, e_input, n_input, consume,
    output m_reg, e_reg, n_reg, word_cnt, busy, operands_ready, overrun, n_even
  );
endinterface

// File: rtl/operand_shift_reg.sv
// One operand lane: shifts a word in at the LSB end; first word ends up on top.
module operand_shift_reg
  import rsa_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_LENGTH-1:0] q
);

  logic [DATA_LENGTH-1:0] q_q, q_d;

  // Clear wins over shift so a restart never keeps a stray word.
  always_comb begin
    q_d = q_q;
    if (clr)           q_d = '0;
    else if (shift_en) q_d = {q_q[DATA_LENGTH-DATA_WIDTH-1:0], din};
  end

  // Lane storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rsa_operand_loader.sv
// Assembles 32 serial words per lane into 1024-bit operands for MonPro.
module rsa_operand_loader
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  rsa_operand_loader_if.slave bus
);

  ld_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 overrun_q, overrun_d;
  logic                 n_even_q, n_even_d;
  logic                 clr, shift_en, n_lsb_next;

  // Next-state, counter and status computation.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    overrun_d  = overrun_q;
    clr        = 1'b0;
    shift_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.startInput) begin
          state_d    = LOAD;
          clr        = 1'b1;
          word_cnt_d = '0;
          overrun_d  = 1'b0;
        end
      end
      LOAD: begin
        if (bus.startInput) begin
          clr        = 1'b1;
          word_cnt_d = '0;
        end else if (bus.in_valid) begin
          shift_en   = 1'b1;
          word_cnt_d = CNT_WIDTH'(word_cnt_q + CNT_WIDTH'(1));
          if (word_cnt_q == CNT_WIDTH'(TOTAL_ADDR - 1)) state_d = FULL;
        end
      end
      FULL: begin
        if (bus.in_valid) overrun_d = 1'b1;
        if (bus.consume) begin
          word_cnt_d = '0;
          if (bus.startInput) begin
            state_d   = LOAD;
            clr       = 1'b1;
            overrun_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    n_lsb_next = shift_en ? bus.n_input[0] : bus.n_reg[0];
    busy_d     = (state_d == LOAD);
    ready_d    = (state_d == FULL);
    n_even_d   = (state_d == FULL) && !n_lsb_next;
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      n_even_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
      n_even_q   <= n_even_d;
    end
  end

  operand_shift_reg u_m (.clk(clk), .reset(reset), .clr(clr), .shift_en(shift_en),
                         .din(bus.m_input), .q(bus.m_reg));
  operand_shift_reg u_e (.clk(clk), .reset(reset), .clr(clr), .shift_en(shift_en),
                         .din(bus.e_input), .q(bus.e_reg));
  operand_shift_reg u_n (.clk(clk), .reset(reset), .clr(clr), .shift_en(shift_en),
                         .din(bus.n_input), .q(bus.n_reg));

  assign bus.word_cnt       = word_cnt_q;
  assign bus.busy           = busy_q;
  assign bus.operands_ready = ready_q;
  assign bus.overrun        = overrun_q;
  assign bus.n_even         = n_even_q;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed/randomized bench for rsa_operand_loader against a word-list model.
module tb_rsa_operand_loader;
  import rsa_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] wm[32];
  logic [31:0] we[32];
  logic [31:0] wn[32];
  logic [1023:0] snap;

  rsa_operand_loader_if ifc ();
  rsa_operand_loader dut (.clk(clk), .reset(reset), .bus(ifc));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int k;
    k = 0;
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      for (int i = 31; i >= 0; i--)
        if (obs[32*i +: 32] !== exp[32*i +: 32]) k = i;
      $error("FAIL %s word_bits[%0d] observed=%h expected=%h",
             tag, 32*k, obs[32*k +: 32], exp[32*k +: 32]);
    end
  endtask

  // Expected register after cnt words: word i sits cnt-1-i slots above the LSB.
  function automatic logic [1023:0] model(input int lane, input int cnt);
    logic [1023:0] r;
    logic [31:0]   w;
    r = '0;
    for (int i = 0; i < cnt; i++) begin
      w = (lane == 0) ? wm[i] : (lane == 1) ? we[i] : wn[i];
      r[32*(cnt-1-i) +: 32] = w;
    end
    return r;
  endfunction

  task automatic chk_regs(input string tag, input int cnt);
    chk_w({tag, ".m"}, ifc.m_reg, model(0, cnt));
    chk_w({tag, ".e"}, ifc.e_reg, model(1, cnt));
    chk_w({tag, ".n"}, ifc.n_reg, model(2, cnt));
  endtask

  task automatic chk_status(input string tag, input int cnt, input bit busy,
                            input bit rdy, input bit ovr, input bit neven);
    chk({tag, ".cnt"},  32'(ifc.word_cnt), 32'(cnt));
    chk({tag, ".busy"}, 32'(ifc.busy), 32'(busy));
    chk({tag, ".rdy"},  32'(ifc.operands_ready), 32'(rdy));
    chk({tag, ".ovr"},  32'(ifc.overrun), 32'(ovr));
    chk({tag, ".neven"}, 32'(ifc.n_even), 32'(neven));
  endtask

  task automatic gen_words();
    for (int i = 0; i < 32; i++) begin
      wm[i] = $urandom;
      we[i] = $urandom;
      wn[i] = $urandom;
    end
  endtask

  task automatic send(input int i);
    ifc.in_valid = 1'b1;
    ifc.m_input  = wm[i];
    ifc.e_input  = we[i];
    ifc.n_input  = wn[i];
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i < to; i++) send(i);
  endtask

  task automatic pulse_start();
    ifc.startInput = 1'b1;
    tick();
    ifc.startInput = 1'b0;
  endtask

  task automatic pulse_consume();
    ifc.consume = 1'b1;
    tick();
    ifc.consume = 1'b0;
  endtask

  initial begin
    ifc.startInput = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.consume    = 1'b0;
    ifc.m_input    = '0;
    ifc.e_input    = '0;
    ifc.n_input    = '0;

    // Reset held for two cycles.
    tick();
    tick();
    chk_status("rst", 0, 0, 0, 0, 0);
    chk_regs("rst", 0);
    reset = 1'b1;
    tick();
    chk_status("rel", 0, 0, 0, 0, 0);

    // in_valid with no start is ignored.
    gen_words();
    send_range(0, 3);
    chk_status("idle_valid", 0, 0, 0, 0, 0);
    chk_regs("idle_valid", 0);

    // Full load with fixed boundary words; in_valid concurrent with start is dropped.
    gen_words();
    wn[0] = 32'h0E8780E1; wn[31] = 32'h57BB7202;
    wm[0] = 32'h8FC30498; we[0] = 32'h534ab101;
    ifc.in_valid = 1'b1;
    ifc.n_input  = 32'hDEADBEEF;
    pulse_start();
    ifc.in_valid = 1'b0;
    chk_status("start", 0, 1, 0, 0, 0);
    send_range(0, 31);
    chk_status("w31", 31, 1, 0, 0, 0);
    chk_regs("w31", 31);
    send(31);
    chk_status("full1", 32, 0, 1, 0, 1);
    chk_regs("full1", 32);
    chk("n_top", ifc.n_reg[1023:992], 32'h0E8780E1);
    chk("n_bot", ifc.n_reg[31:0], 32'h57BB7202);
    chk("m_top", ifc.m_reg[1023:992], 32'h8FC30498);

    // startInput alone in FULL is ignored; consume releases.
    pulse_start();
    chk_status("full_start", 32, 0, 1, 0, 1);
    chk_regs("full_start", 32);
    pulse_consume();
    chk_status("consume1", 0, 0, 0, 0, 0);
    chk_regs("consume1", 32);

    // Odd modulus.
    wn[31] = 32'h57BB7203;
    pulse_start();
    chk_regs("start2", 0);
    send_range(0, 32);
    chk_status("full2", 32, 0, 1, 0, 0);
    chk_regs("full2", 32);
    pulse_consume();
    chk_status("consume2", 0, 0, 0, 0, 0);

    // Stall in the middle; consume outside FULL is ignored.
    gen_words();
    pulse_start();
    send_range(0, 10);
    ifc.consume = 1'b1;
    for (int s = 0; s < 5; s++) tick();
    ifc.consume = 1'b0;
    chk_status("stall", 10, 1, 0, 0, 0);
    chk_regs("stall", 10);
    send_range(10, 31);
    chk_status("stall31", 31, 1, 0, 0, 0);
    send(31);
    chk_status("stall_full", 32, 0, 1, 0, ~wn[31][0]);
    chk_regs("stall_full", 32);
    pulse_consume();

    // Restart after 17 words, concurrent word dropped.
    gen_words();
    pulse_start();
    send_range(0, 17);
    chk_regs("part17", 17);
    ifc.in_valid = 1'b1;
    ifc.m_input  = 32'h12345678;
    ifc.e_input  = 32'h12345678;
    ifc.n_input  = 32'h12345678;
    pulse_start();
    ifc.in_valid = 1'b0;
    chk_status("restart", 0, 1, 0, 0, 0);
    chk_regs("restart", 0);
    gen_words();
    send_range(0, 32);
    chk_status("full3", 32, 0, 1, 0, ~wn[31][0]);
    chk_regs("full3", 32);

    // Overrun in FULL, then consume+start together.
    ifc.in_valid = 1'b1;
    ifc.m_input  = 32'hDEADBEEF;
    ifc.e_input  = 32'hDEADBEEF;
    ifc.n_input  = 32'hDEADBEEF;
    tick();
    ifc.in_valid = 1'b0;
    chk_status("overrun", 32, 0, 1, 1, ~wn[31][0]);
    chk_regs("overrun", 32);
    ifc.consume = 1'b1;
    pulse_start();
    ifc.consume = 1'b0;
    chk_status("cons_start", 0, 1, 0, 0, 0);
    chk_regs("cons_start", 0);

    // Reset mid-load discards partial data.
    gen_words();
    send_range(0, 5);
    snap = model(2, 5);
    chk_w("mid.n", ifc.n_reg, snap);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_status("midrst", 0, 0, 0, 0, 0);
    chk_regs("midrst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rsa_operand_loader.md
Name: rsa_operand_loader

Overview:
- Receive side of the serial operand interface into the Montgomery exponentiation core (MonPro).
- Accepts one 32-bit word each of modulus n, ciphertext m and private exponent e per valid cycle.
- Assembles 32 words into three 1024-bit operand registers and presents them to MonPro with a ready/consume handshake.
- Flags malformed loads: overrun, and an even modulus, which Montgomery arithmetic cannot use.

Parameters:
- DATA_WIDTH, 32, word width of each serial operand lane.
- ADDR_WIDTH, 5, log2 of words per operand.
- TOTAL_ADDR, 2**ADDR_WIDTH = 32, words per operand.
- DATA_LENGTH, DATA_WIDTH*TOTAL_ADDR = 1024, operand width in bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- startInput  in  1  arms a new load; clears buffers and counter.
- in_valid  in  1  qualifies m_input/e_input/n_input this cycle.
- m_input  in  DATA_WIDTH  ciphertext word.
- e_input  in  DATA_WIDTH  private-exponent word.
- n_input  in  DATA_WIDTH  modulus word.
- consume  in  1  MonPro has latched operands; release the buffers.
- m_reg  out  DATA_LENGTH  assembled ciphertext.
- e_reg  out  DATA_LENGTH  assembled exponent.
- n_reg  out  DATA_LENGTH  assembled modulus.
- word_cnt  out  ADDR_WIDTH+1  words received in the current load (0..32).
- busy  out  1  load in progress.
- operands_ready  out  1  all 32 words held and stable.
- overrun  out  1  sticky; in_valid seen while FULL.
- n_even  out  1  n_reg[0]==0 while operands_ready.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; all outputs and registers 0.
- Word order: the first word received is the most significant.
  - Each accepted word shifts in at the LSB end: reg <= {reg[DATA_LENGTH-DATA_WIDTH-1:0], word}.
  - After 32 words, word 0 occupies bits [1023:992].
- FSM states: IDLE, LOAD, FULL.
- IDLE:
  - startInput=1 -> LOAD; clear m/e/n_reg, word_cnt=0, overrun=0.
  - in_valid in IDLE, including the same cycle as startInput, is ignored.
- LOAD:
  - busy=1.
  - in_valid=1 -> shift all three lanes in lockstep; word_cnt += 1.
  - When word_cnt==31 and in_valid=1: capture the word, word_cnt=32, next state FULL; operands_ready=1 from the following cycle.
  - startInput=1 in LOAD restarts: clear buffers, word_cnt=0, stay in LOAD. The concurrent in_valid word is dropped; startInput has priority.
  - in_valid=0 is a stall; registers hold with no timeout.
- FULL:
  - operands_ready=1, busy=0.
  - m/e/n_reg held stable until consume.
  - n_even = ~n_reg[0], registered together with operands_ready.
  - in_valid=1 -> word ignored, overrun<=1 (sticky until next startInput or reset).
  - consume=1 -> IDLE next cycle: operands_ready=0, n_even=0, word_cnt=0. Registers keep their values until the next start.
  - consume and startInput in the same cycle -> go directly to LOAD with buffers cleared.
  - startInput alone in FULL is ignored.
- consume outside FULL is ignored.
- Reset mid-load or in FULL: immediate return to the reset state; a partial load is discarded.
- Latency: last valid word -> operands_ready high on the next rising edge (1 cycle).
- word_cnt never wraps; it saturates at 32 in FULL.

Decomposition:
- Shared package rsa_pkg:
  - DATA_WIDTH, ADDR_WIDTH, TOTAL_ADDR, DATA_LENGTH.
  - Loader state encoding (IDLE=2'd0, LOAD=2'd1, FULL=2'd2).
  - Reused by MonPro and the result unloader.
- One sub-module, operand_shift_reg:
  - Ports: clk, reset, clr, shift_en, din[DATA_WIDTH], q[DATA_LENGTH].
  - Instantiated three times (m, e, n); the FSM and counter stay in the top.

Test Plan:
- Reset held low 2 cycles, then released -> all outputs 0, state IDLE; in_valid pulses with no startInput leave word_cnt=0.
- startInput, then 32 valid words (n word0=32'h0E8780E1 ... word31=32'h57BB7202; m word0=32'h8FC30498; e word0=32'h534ab101):
  - Cycle after word31: operands_ready=1, word_cnt=32, n_reg[1023:992]=32'h0E8780E1, n_reg[31:0]=32'h57BB7202, m_reg[1023:992]=32'h8FC30498.
  - n_even=1, because 0x...7202 is even.
- Same load with last n word 32'h57BB7203 -> n_even=0. Then pulse consume -> next cycle operands_ready=0, state IDLE.
- Load 10 words, drop in_valid for 5 cycles, then resume 22 words -> operands_ready after word 32 only; the stall leaves data unchanged.
- startInput after 17 words (concurrent in_valid word dropped), then a full 32-word load -> contents equal the second sequence only; word_cnt=32.
- In FULL, drive in_valid with 32'hDEADBEEF -> overrun=1 and registers unchanged. consume+startInput in one cycle -> LOAD, buffers 0, overrun=0.
